k12a_mem_if: RTL
================

Name: k12a_mem_if

Overview:
- Bus-cycle sequencer directly downstream of the address calculation unit.
- Samples the 16-bit address on addr_bus when the control unit requests a memory access.
- Decodes the address into RAM or I/O space and runs a setup/access/hold strobe sequence on the external asynchronous bus, with per-region wait states.
- Returns read data and a one-cycle completion pulse to the control unit.

Parameters:
- MEM_WAIT, 1: extra ACCESS cycles for RAM region (0..15).
- IO_WAIT, 3: extra ACCESS cycles for I/O region (0..15).
- IO_BASE, 16'hFF00: addresses >= IO_BASE select I/O space; lower addresses select RAM.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_start  in  1  control unit requests an access; sampled only in IDLE.
- mem_write  in  1  1 = write, 0 = read; sampled with mem_start.
- addr_bus  in  16  address driven by the ACU; sampled with mem_start.
- wdata  in  8  write data; sampled with mem_start.
- mem_busy  out  1  high in every state except IDLE.
- mem_done  out  1  one-cycle pulse in HOLD.
- rdata  out  8  last read data, held until the next read completes.
- ext_addr  out  16  latched address to external bus.
- ext_wdata  out  8  latched write data.
- ext_wdata_oe  out  1  external data-bus driver enable.
- ext_rdata  in  8  external read data.
- ext_ram_cs_n  out  1  RAM chip select, active low.
- ext_io_cs_n  out  1  I/O chip select, active low.
- ext_oe_n  out  1  read strobe, active low.
- ext_we_n  out  1  write strobe, active low.

Behaviour:
- Reset values (asynchronous on reset_n low, immediate):
  - state = IDLE.
  - mem_busy = 0, mem_done = 0.
  - rdata = 8'h00, ext_addr = 16'h0000, ext_wdata = 8'h00.
  - ext_wdata_oe = 0.
  - ext_ram_cs_n = ext_io_cs_n = ext_oe_n = ext_we_n = 1.
- Reset mid-operation: all strobes deassert at once, no mem_done is produced, and the access is abandoned.
- States are IDLE, SETUP, ACCESS and HOLD. All outputs are registered or decoded from state and latched registers only; there are no combinational paths from the inputs.
- IDLE:
  - Strobes and chip selects are deasserted.
  - If mem_start = 1 at a rising edge: latch addr_bus into ext_addr, mem_write into we_reg, wdata into ext_wdata, and the region bit (ext_addr >= IO_BASE, unsigned compare) into is_io. Then go to SETUP.
- SETUP (exactly 1 cycle):
  - The chip select for the latched region is asserted; oe/we remain deasserted.
  - The wait counter loads IO_WAIT if is_io, else MEM_WAIT.
  - Next state is ACCESS.
- ACCESS (lasts WAIT+1 cycles):
  - Chip select is held; ext_oe_n = 0 for a read, ext_we_n = 0 for a write.
  - If the counter != 0, decrement it and stay in ACCESS.
  - If the counter == 0, go to HOLD. On that same edge, a read captures ext_rdata into rdata.
- HOLD (exactly 1 cycle):
  - oe/we are deasserted; chip select and ext_addr are held.
  - mem_done = 1.
  - Next state is IDLE.
- ext_wdata_oe is 1 in SETUP, ACCESS and HOLD of a write, otherwise 0. The driver is therefore enabled before ext_we_n falls and stays enabled after it rises.
- Latency: with mem_start sampled at edge 0, mem_done is high in cycle 3+WAIT. rdata is valid from the cycle after mem_done.
- mem_start while busy (including during HOLD) is ignored; the earliest back-to-back start is the first IDLE cycle.
- ext_addr, ext_wdata and rdata hold their values in IDLE; they do not track addr_bus.
- Boundary addresses: 16'hFEFF selects RAM, 16'hFF00 selects I/O, 16'hFFFF selects I/O.
- WAIT = 0 gives a single ACCESS cycle.
- Exactly one chip select is low at a time; both are high in IDLE.

Decomposition:
- mem_state_t (2-bit enum: MEM_STATE_IDLE, MEM_STATE_SETUP, MEM_STATE_ACCESS, MEM_STATE_HOLD) goes in the shared k12a.inc.sv alongside the other k12a typedefs.
- The default IO_BASE and wait constants are also defined there.
- Sub-module k12a_wait_counter: 4-bit loadable down-counter with a zero flag (ports: clock, reset_n, load, load_value, dec, zero).

Test Plan:
- Read RAM, MEM_WAIT=1: addr_bus=16'h1234, mem_start=1 at edge 0, ext_rdata=8'hA5 → ext_ram_cs_n low in cycles 1-4; ext_oe_n low in cycles 2-3; mem_done high in cycle 4 only; rdata=8'hA5 from cycle 5; ext_io_cs_n stays 1.
- Write I/O, IO_WAIT=3: addr_bus=16'hFF10, wdata=8'h3C, mem_write=1 → ext_io_cs_n low in cycles 1-6; ext_we_n low in cycles 2-5; ext_wdata_oe high in cycles 1-6 with ext_wdata=8'h3C; mem_done in cycle 6; rdata unchanged.
- Region boundary: reads at 16'hFEFF and 16'hFF00 → the first uses RAM select and 1 wait; the second uses I/O select and 3 waits (done in cycles 4 and 6 relative to each start).
- Busy rejection: assert mem_start continuously with addr_bus changing every cycle → each access uses only the address sampled in IDLE; a new access starts one cycle after each mem_done; no access begins during HOLD.
- Reset mid-access: pull reset_n low during ACCESS of a write → ext_we_n, chip selects and ext_wdata_oe go high immediately (asynchronously); no mem_done; after release, mem_busy=0 and the next mem_start runs a normal cycle.
- Zero-wait variant (MEM_WAIT=0): read at 16'h0000 → exactly one ACCESS cycle; mem_done in cycle 3.

Source files
------------

// File: rtl/k12a_mem_if_pkg.sv
// k12a_mem_if_pkg
//   Shared types and default constants for the k12a memory bus sequencer.
//   - mem_state_t : bus-cycle state encoding (IDLE, SETUP, ACCESS, HOLD)
//   - K12A_MEM_WAIT_DEFAULT / K12A_IO_WAIT_DEFAULT : default extra ACCESS cycles
//   - K12A_IO_BASE_DEFAULT : first address of the I/O region
package k12a_mem_if_pkg;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE   = 2'd0,
        MEM_STATE_SETUP  = 2'd1,
        MEM_STATE_ACCESS = 2'd2,
        MEM_STATE_HOLD   = 2'd3
    } mem_state_t;

    localparam int          K12A_MEM_WAIT_DEFAULT = 1;
    localparam int          K12A_IO_WAIT_DEFAULT  = 3;
    localparam logic [15:0] K12A_IO_BASE_DEFAULT  = 16'hFF00;

    // Picks the per-region wait count, truncated to the 4-bit counter width.
    function automatic logic [3:0] waitFor(input logic isIo, input int memWait, input int ioWait);
        logic [3:0] w_value;
        w_value = isIo ? 4'(ioWait) : 4'(memWait);
        return w_value;
    endfunction

endpackage

// File: rtl/k12a_mem_if_wait_counter.sv
// k12a_wait_counter
//   4-bit loadable down-counter used to stretch the ACCESS phase.
//   Ports:
//     clock      - system clock, rising edge
//     reset_n    - asynchronous active-low reset (count clears to 0)
//     load       - load load_value into the counter (has priority over dec)
//     load_value - value to load
//     dec        - decrement by one; ignored when already zero
//     zero       - high while the count is zero
module k12a_wait_counter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] r_count;

    // Count register: load wins over decrement, and the count saturates at
    // zero so a stray dec can never wrap around to 15.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign zero = (r_count == 4'd0);

endmodule

// File: rtl/k12a_mem_if.sv
// k12a_mem_if
//   Bus-cycle sequencer between the k12a control unit and the external
//   asynchronous RAM / I/O bus. An access runs SETUP -> ACCESS (WAIT+1
//   cycles) -> HOLD, with the wait count chosen by the address region.
//   Ports:
//     clock, reset_n           - clock and asynchronous active-low reset
//     mem_start, mem_write     - access request and direction (sampled in IDLE)
//     addr_bus, wdata          - address and write data (sampled in IDLE)
//     mem_busy, mem_done       - busy outside IDLE, one-cycle done pulse in HOLD
//     rdata                    - last read data, held until the next read
//     ext_addr, ext_wdata      - latched address / write data to the bus
//     ext_wdata_oe             - write-data driver enable
//     ext_rdata                - read data from the bus
//     ext_ram_cs_n, ext_io_cs_n- active-low chip selects
//     ext_oe_n, ext_we_n       - active-low read / write strobes
module k12a_mem_if
    import k12a_mem_if_pkg::*;
#(
    parameter int          MEM_WAIT = K12A_MEM_WAIT_DEFAULT,
    parameter int          IO_WAIT  = K12A_IO_WAIT_DEFAULT,
    parameter logic [15:0] IO_BASE  = K12A_IO_BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_start,
    input  logic        mem_write,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  wdata,
    output logic        mem_busy,
    output logic        mem_done,
    output logic [7:0]  rdata,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_wdata_oe,
    input  logic [7:0]  ext_rdata,
    output logic        ext_ram_cs_n,
    output logic        ext_io_cs_n,
    output logic        ext_oe_n,
    output logic        ext_we_n
);

    mem_state_t  r_state;
    mem_state_t  w_next_state;
    logic        r_we;
    logic        r_is_io;
    logic [15:0] r_ext_addr;
    logic [7:0]  r_ext_wdata;
    logic [7:0]  r_rdata;
    logic        w_load;
    logic        w_dec;
    logic        w_zero;
    logic [3:0]  w_load_value;
    logic        w_accept;
    logic        w_capture;

    // A request is only honoured in IDLE; starts during a cycle are dropped.
    assign w_accept  = (r_state == MEM_STATE_IDLE) && mem_start;
    // Read data is sampled on the edge that leaves the last ACCESS cycle.
    assign w_capture = (r_state == MEM_STATE_ACCESS) && w_zero && !r_we;

    assign w_load_value = waitFor(r_is_io, MEM_WAIT, IO_WAIT);

    k12a_wait_counter u_wait_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (w_load),
        .load_value (w_load_value),
        .dec        (w_dec),
        .zero       (w_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MEM_STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latches: they only change when a new access is accepted, so
    // the external address and data stay stable through IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we        <= 1'b0;
            r_is_io     <= 1'b0;
            r_ext_addr  <= 16'h0000;
            r_ext_wdata <= 8'h00;
        end else if (w_accept) begin
            r_we        <= mem_write;
            r_is_io     <= (addr_bus >= IO_BASE);
            r_ext_addr  <= addr_bus;
            r_ext_wdata <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 8'h00;
        end else if (w_capture) begin
            r_rdata <= ext_rdata;
        end
    end

    // Next-state and wait-counter control.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        unique case (r_state)
            MEM_STATE_IDLE: begin
                if (mem_start) begin
                    w_next_state = MEM_STATE_SETUP;
                end
            end
            MEM_STATE_SETUP: begin
                w_load       = 1'b1;
                w_next_state = MEM_STATE_ACCESS;
            end
            MEM_STATE_ACCESS: begin
                if (w_zero) begin
                    w_next_state = MEM_STATE_HOLD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            MEM_STATE_HOLD: begin
                w_next_state = MEM_STATE_IDLE;
            end
            default: begin
                w_next_state = MEM_STATE_IDLE;
            end
        endcase
    end

    // Bus outputs decode from state and latched request only, so a reset
    // drops every strobe immediately and no input reaches an output.
    assign mem_busy     = (r_state != MEM_STATE_IDLE);
    assign mem_done     = (r_state == MEM_STATE_HOLD);
    assign ext_ram_cs_n = !(mem_busy && !r_is_io);
    assign ext_io_cs_n  = !(mem_busy && r_is_io);
    assign ext_oe_n     = !((r_state == MEM_STATE_ACCESS) && !r_we);
    assign ext_we_n     = !((r_state == MEM_STATE_ACCESS) && r_we);
    assign ext_wdata_oe = mem_busy && r_we;
    assign ext_addr     = r_ext_addr;
    assign ext_wdata    = r_ext_wdata;
    assign rdata        = r_rdata;

endmodule
